// File: rtl/rr_arbiter3.sv
// rr_arbiter3: round-robin arbiter granting one shared resource to three level requesters.
// Optional forced release after TIMEOUT cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter3 #(
   parameter int TIMEOUT = 8,
   parameter int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    req,
   output logic [2:0]    grant,
   output logic          busy,
   output logic [1:0]    owner,
   output logic [CW-1:0] hold_cnt,
   output logic          timeout
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t        state_q, state_d;
   logic [2:0]    grant_q, grant_d;
   logic          busy_q, busy_d;
   logic [1:0]    owner_q, owner_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;
   logic [1:0]    c1, c2, win;
   logic          to_hit;
`ifdef ARB_TIMEOUT_EN
   assign to_hit = hold_q == CW'(TIMEOUT);
`else
   assign to_hit = 1'b0;
`endif
   // Search order ptr+1, ptr+2, then the previous winner last.
   always_comb begin
      c1  = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
      c2  = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
      win = req[c1] ? c1 : req[c2] ? c2 : ptr_q;
   end
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      if (state_q == IDLE) begin
         if (|req) begin
            grant_d = 3'b001 << win;
            owner_d = win;
            ptr_d   = win;
            hold_d  = CW'(1);
            state_d = GRANT;
         end
      end else if (!req[owner_q] || to_hit) begin
         grant_d   = 3'b000;
         owner_d   = 2'd3;
         hold_d    = '0;
         timeout_d = req[owner_q] & to_hit;
         state_d   = IDLE;
      end else begin
         hold_d = &hold_q ? hold_q : hold_q + CW'(1);
      end
      busy_d = |grant_d;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= 3'b000;
         busy_q    <= 1'b0;
         owner_q   <= 2'd3;
         ptr_q     <= 2'd2;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end
   assign grant    = grant_q;
   assign busy     = busy_q;
   assign owner    = owner_q;
   assign hold_cnt = hold_q;
   assign timeout  = timeout_q;
endmodule

// File: tb/tb_rr_arbiter3.sv
// tb_rr_arbiter3: randomized and directed checks of rr_arbiter3 against a behavioural model.
module tb_rr_arbiter3;
   localparam int TO   = 8;
   localparam int CW   = $clog2(TO + 1);
   localparam int HMAX = (1 << CW) - 1;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    req = 3'b000;
   logic [2:0]    grant;
   logic          busy;
   logic [1:0]    owner;
   logic [CW-1:0] hold_cnt;
   logic          timeout;
   int checks = 0, failures = 0;
   int m_own = -1, m_ptr = 2, m_hold = 0;
   bit m_to = 1'b0;

   rr_arbiter3 #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
      .busy(busy), .owner(owner), .hold_cnt(hold_cnt), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] eg();
      return m_own < 0 ? 3'b000 : 3'(1 << m_own);
   endfunction
   function automatic logic [1:0] eo();
      return m_own < 0 ? 2'd3 : 2'(m_own);
   endfunction

   // Drive req for one clock edge and advance the reference model by that edge.
   task automatic step(input logic [2:0] r);
      req = r;
      @(posedge clk);
      if (!rst_n) begin
         m_own = -1; m_ptr = 2; m_hold = 0; m_to = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_own < 0) begin
            for (int k = 1; k <= 3; k++) begin
               int i;
               i = (m_ptr + k) % 3;
               if (r[i] && m_own < 0) begin
                  m_own = i; m_ptr = i; m_hold = 1;
               end
            end
         end else if (!r[m_own]) begin
            m_own = -1; m_hold = 0;
         end else if (TO_EN && m_hold == TO) begin
            m_own = -1; m_hold = 0; m_to = 1'b1;
         end else begin
            m_hold = m_hold < HMAX ? m_hold + 1 : HMAX;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(3'($urandom_range(0, 7)));
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(3'b111);
      step(3'b111);
      checks++;
      if (grant !== 3'b000 || owner !== 2'd3 || busy !== 1'b0 || hold_cnt !== '0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset: grant=%b owner=%0d busy=%b hold=%0d to=%b, need 000/3/0/0/0", grant, owner, busy, hold_cnt, timeout);
      end
      rst_n = 1'b1;
      step(3'b111);
      checks++;
      if (grant !== 3'b001 || owner !== 2'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_grant: grant=%b owner=%0d busy=%b, need 001/0/1", grant, owner, busy);
      end
   endtask

   task automatic test_rotation();
      logic [2:0] seq[$];
      logic [2:0] prev, r;
      do_reset();
      prev = 3'b000;
      for (int c = 0; c < 10; c++) begin
         r = 3'b111;
         if (m_own >= 0 && m_hold >= 2) r[m_own] = 1'b0;
         step(r);
         checks++;
         if (grant !== eg() || owner !== eo()) begin
            failures++;
            $display("FAIL rotation c%0d: grant=%b owner=%0d, need %b/%0d", c, grant, owner, eg(), eo());
         end
         checks++;
         if (prev != 3'b000 && grant != 3'b000 && grant != prev) begin
            failures++;
            $display("FAIL rotation_gap c%0d: grant %b follows %b, need an idle cycle", c, grant, prev);
         end
         if (grant != 3'b000 && grant != prev) seq.push_back(grant);
         prev = grant;
      end
      checks++;
      if (seq.size() < 4 || seq[0] !== 3'b001 || seq[1] !== 3'b010 || seq[2] !== 3'b100 || seq[3] !== 3'b001) begin
         failures++;
         $display("FAIL rotation_order: got %0d grants starting %b, need 001,010,100,001", seq.size(), seq.size() > 0 ? seq[0] : 3'b000);
      end
   endtask

   task automatic test_single();
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         step(3'b100);
         checks++;
         if (grant !== eg() || hold_cnt !== CW'(m_hold) || timeout !== m_to) begin
            failures++;
            $display("FAIL single c%0d: grant=%b hold=%0d to=%b, need %b/%0d/%b", c, grant, hold_cnt, timeout, eg(), m_hold, m_to);
         end
      end
      step(3'b000);
      checks++;
      if (grant !== 3'b000 || owner !== 2'd3 || hold_cnt !== '0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_drop: grant=%b owner=%0d hold=%0d busy=%b, need idle", grant, owner, hold_cnt, busy);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int c = 1; c <= HMAX + 5; c++) begin
         step(3'b001);
         checks++;
         if (grant !== eg() || hold_cnt !== CW'(m_hold) || timeout !== m_to) begin
            failures++;
            $display("FAIL saturate c%0d: grant=%b hold=%0d to=%b, need %b/%0d/%b", c, grant, hold_cnt, timeout, eg(), m_hold, m_to);
         end
      end
      step(3'b000);
   endtask

   task automatic test_simultaneous();
      do_reset();
      step(3'b001);
      step(3'b001);
      step(3'b010);
      checks++;
      if (grant !== 3'b000 || owner !== 2'd3) begin
         failures++;
         $display("FAIL simultaneous_release: grant=%b owner=%0d, need 000/3", grant, owner);
      end
      step(3'b010);
      checks++;
      if (grant !== 3'b010 || owner !== 2'd1) begin
         failures++;
         $display("FAIL simultaneous_next: grant=%b owner=%0d, need 010/1", grant, owner);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(3'b010);
      step(3'b010);
      step(3'b010);
      checks++;
      if (grant !== 3'b010 || hold_cnt !== CW'(3)) begin
         failures++;
         $display("FAIL reset_mid_setup: grant=%b hold=%0d, need 010/3", grant, hold_cnt);
      end
      rst_n = 1'b0;
      step(3'b010);
      rst_n = 1'b1;
      checks++;
      if (grant !== 3'b000 || hold_cnt !== '0 || owner !== 2'd3) begin
         failures++;
         $display("FAIL reset_mid: grant=%b hold=%0d owner=%0d, need 000/0/3", grant, hold_cnt, owner);
      end
      step(3'b011);
      checks++;
      if (grant !== 3'b001) begin
         failures++;
         $display("FAIL reset_mid_ptr: grant=%b, need 001", grant);
      end
   endtask

   task automatic test_timeout();
      int pulses;
      bit moved;
      pulses = 0;
      moved = 1'b0;
      do_reset();
      for (int c = 0; c < 2 * TO + 6; c++) begin
         step(3'b011);
         checks++;
         if (grant !== eg() || hold_cnt !== CW'(m_hold) || timeout !== m_to) begin
            failures++;
            $display("FAIL timeout c%0d: grant=%b hold=%0d to=%b, need %b/%0d/%b", c, grant, hold_cnt, timeout, eg(), m_hold, m_to);
         end
         if (timeout === 1'b1) pulses++;
         if (grant === 3'b010) moved = 1'b1;
      end
      checks++;
      if (TO_EN ? (pulses == 0 || !moved) : (pulses != 0 || moved)) begin
         failures++;
         $display("FAIL timeout_summary: pulses=%0d handed_to_1=%0d, need %0d", pulses, moved, TO_EN);
      end
      step(3'b000);
   endtask

   task automatic test_random();
      logic [2:0] r;
      r = 3'b000;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 5) == 0) r = 3'($urandom_range(0, 7));
         rst_n = $urandom_range(0, 60) != 0;
         step(r);
         checks++;
         if (grant !== eg() || owner !== eo() || busy !== (m_own >= 0) || hold_cnt !== CW'(m_hold) || timeout !== m_to || !$onehot0(grant)) begin
            failures++;
            $display("FAIL random c%0d req=%b: grant=%b owner=%0d busy=%b hold=%0d to=%b, need %b/%0d/%b/%0d/%b",
                     c, r, grant, owner, busy, hold_cnt, timeout, eg(), eo(), m_own >= 0, m_hold, m_to);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_single();
      test_saturate();
      test_simultaneous();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
